// File: rtl/sync_divider.sv
// sync_divider: sequential unsigned restoring divider.
// Divides a 2*WIDTH-bit dividend by a WIDTH-bit divisor, producing one
// quotient bit per clock, using the same start/done handshake as the
// team's synchronous multiplier.
module sync_divider #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [2*WIDTH-1:0]   dividend,
   input  logic [WIDTH-1:0]     divisor,
   output logic [2*WIDTH-1:0]   quotient,
   output logic [WIDTH-1:0]     remainder,
   output logic                 done,
   output logic                 busy,
   output logic                 div_by_zero
);

   localparam int CNT_W = $clog2(2*WIDTH+1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_CALC   = 2'd1;
   localparam logic [1:0] S_FINISH = 2'd2;

   localparam logic [CNT_W-1:0] ITER = CNT_W'(2*WIDTH);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   logic [1:0]           state;
   logic [CNT_W-1:0]     cnt;
   logic                 zero_div;

   logic [2*WIDTH-1:0]   dvd_reg;
   logic [WIDTH-1:0]     dsr_reg;
   logic [WIDTH-1:0]     prem;
   logic [2*WIDTH-1:0]   q_reg;
   logic [WIDTH:0]       step;

   // One restoring iteration: returns {quotient bit, new partial remainder}.
   // The incoming partial remainder is always below the divisor, so the
   // shifted value fits in WIDTH+1 bits and the result fits back in WIDTH.
   function automatic logic [WIDTH:0] restore_step(input logic [WIDTH-1:0] pr,
                                                   input logic             msb,
                                                   input logic [WIDTH-1:0] d);
      logic [WIDTH:0] shifted;
      logic [WIDTH:0] diff;
      shifted = {pr, msb};
      diff    = shifted - {1'b0, d};
      if (shifted >= {1'b0, d})
         restore_step = {1'b1, diff[WIDTH-1:0]};
      else
         restore_step = {1'b0, shifted[WIDTH-1:0]};
   endfunction

   // Combinational trial subtraction for the current CALC iteration.
   always_comb begin
      step = restore_step(prem, dvd_reg[2*WIDTH-1], dsr_reg);
   end

   // Control FSM and result registers; reset zeroes every visible output.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         cnt         <= '0;
         zero_div    <= 1'b0;
         done        <= 1'b0;
         busy        <= 1'b0;
         div_by_zero <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  busy     <= 1'b1;
                  cnt      <= ITER;
                  zero_div <= (divisor == '0);
                  state    <= (divisor == '0) ? S_FINISH : S_CALC;
               end else if (done) begin
                  // busy covers the done cycle and drops on the edge after it
                  busy <= 1'b0;
               end
            end
            S_CALC: begin
               cnt <= cnt - ONE;
               if (cnt == ONE)
                  state <= S_FINISH;
            end
            S_FINISH: begin
               done  <= 1'b1;
               state <= S_IDLE;
               if (zero_div) begin
                  quotient    <= '1;
                  remainder   <= dvd_reg[WIDTH-1:0];
                  div_by_zero <= 1'b1;
               end else begin
                  quotient    <= q_reg;
                  remainder   <= prem;
                  div_by_zero <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Operand capture and shift-subtract datapath (no reset needed).
   always_ff @(posedge clk) begin
      if (state == S_IDLE && start && !rst) begin
         dvd_reg <= dividend;
         dsr_reg <= divisor;
         prem    <= '0;
         q_reg   <= '0;
      end else if (state == S_CALC) begin
         dvd_reg <= {dvd_reg[2*WIDTH-2:0], 1'b0};
         prem    <= step[WIDTH-1:0];
         q_reg   <= {q_reg[2*WIDTH-2:0], step[WIDTH]};
      end
   end

endmodule

// File: tb/tb_sync_divider.sv
// tb_sync_divider: directed and random checks of sync_divider (WIDTH=16)
// with an operand/result scoreboard drained on each done pulse.
module tb_sync_divider;

   localparam int W = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic [2*W-1:0]  dividend = '0;
   logic [W-1:0]    divisor = '0;
   logic [2*W-1:0]  quotient;
   logic [W-1:0]    remainder;
   logic            done;
   logic            busy;
   logic            div_by_zero;

   typedef struct {
      logic [2*W-1:0] a;
      logic [W-1:0]   b;
      logic [2*W-1:0] q;
      logic [W-1:0]   r;
      logic           z;
   } rec_t;

   rec_t sb[$];
   rec_t mrec;
   int   checks = 0;
   int   errors = 0;
   int   ndone  = 0;

   sync_divider #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
      .quotient(quotient), .remainder(remainder), .done(done), .busy(busy),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: compare every done pulse against the oldest pending request.
   always @(negedge clk) begin
      if (!rst && done === 1'b1) begin
         ndone++;
         if (sb.size() == 0) begin
            check("spurious_done", {63'd0, done}, 64'd0);
         end else begin
            mrec = sb.pop_front();
            check("quotient", {32'd0, quotient}, {32'd0, mrec.q});
            check("remainder", {48'd0, remainder}, {48'd0, mrec.r});
            check("div_by_zero", {63'd0, div_by_zero}, {63'd0, mrec.z});
            if (mrec.b != 0) begin
               check("invariant_sum", 64'(quotient) * 64'(mrec.b) + 64'(remainder), 64'(mrec.a));
               check("invariant_rem_lt", {63'd0, (remainder < mrec.b)}, 64'd1);
            end
         end
      end
   end

   // Drive a request (called away from the clock edge); optionally record it.
   task automatic launch(input logic [2*W-1:0] a, input logic [W-1:0] b, input bit push);
      rec_t e;
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      if (push) begin
         e.a = a;
         e.b = b;
         if (b == 0) begin
            e.q = '1; e.r = a[W-1:0]; e.z = 1'b1;
         end else begin
            e.q = a / b; e.r = W'(a % b); e.z = 1'b0;
         end
         sb.push_back(e);
      end
   endtask

   // Called #1 after the accepting edge; waits for done with a cycle budget.
   task automatic wait_done(input int lat, input int intrude);
      int n = 0;
      while (done !== 1'b1 && n < 40) begin
         if (n == intrude) begin
            start = 1'b1; dividend = 32'd50; divisor = 16'd5;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0;
      check("latency", 64'(n), 64'(lat));
      check("busy_in_done_cycle", {63'd0, busy}, 64'd1);
   endtask

   task automatic run(input logic [2*W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      launch(a, b, 1'b1);
      @(posedge clk); #1;
      start    = 1'b0;
      dividend = $urandom;
      divisor  = W'($urandom);
      check("busy_after_accept", {63'd0, busy}, 64'd1);
      wait_done((b == 0) ? 1 : 2*W+1, -1);
      @(posedge clk); #1;
      check("done_one_cycle", {63'd0, done}, 64'd0);
      check("busy_low_after", {63'd0, busy}, 64'd0);
   endtask

   initial begin
      int nd;
      logic [W-1:0] rb;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_quotient", {32'd0, quotient}, 64'd0);
      check("rst_remainder", {48'd0, remainder}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_dbz", {63'd0, div_by_zero}, 64'd0);
      rst = 1'b0;

      // Basic and boundary divisions
      run(32'd1000, 16'd7);
      check("q_1000_7", {32'd0, quotient}, 64'd142);
      check("r_1000_7", {48'd0, remainder}, 64'd6);
      run(32'hFFFF_FFFF, 16'hFFFF);
      check("q_max", {32'd0, quotient}, 64'h0001_0001);
      run(32'd3, 16'd10);
      check("q_small", {32'd0, quotient}, 64'd0);
      check("r_small", {48'd0, remainder}, 64'd3);

      // Divide by zero, then a valid division clears the flag
      run(32'd5, 16'd0);
      check("dbz_set", {63'd0, div_by_zero}, 64'd1);
      check("dbz_q", {32'd0, quotient}, 64'hFFFF_FFFF);
      run(32'd81, 16'd9);
      check("dbz_cleared", {63'd0, div_by_zero}, 64'd0);

      // Start during CALC is ignored; start in the done cycle is accepted
      @(negedge clk);
      launch(32'd100, 16'd9, 1'b1);
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(2*W+1, 10);
      check("q_ignore", {32'd0, quotient}, 64'd11);
      check("r_ignore", {48'd0, remainder}, 64'd1);
      launch(32'd1000, 16'd7, 1'b1);
      @(posedge clk); #1;
      start = 1'b0;
      check("b2b_done_low", {63'd0, done}, 64'd0);
      check("b2b_busy", {63'd0, busy}, 64'd1);
      wait_done(2*W+1, -1);
      @(posedge clk); #1;
      check("b2b_busy_low", {63'd0, busy}, 64'd0);

      // Reset mid-CALC discards the division; coincident start is ignored
      @(negedge clk);
      launch(32'd1000, 16'd7, 1'b0);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      rst = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      check("midrst_quotient", {32'd0, quotient}, 64'd0);
      check("midrst_remainder", {48'd0, remainder}, 64'd0);
      check("midrst_done", {63'd0, done}, 64'd0);
      check("midrst_busy", {63'd0, busy}, 64'd0);
      check("midrst_dbz", {63'd0, div_by_zero}, 64'd0);
      nd = ndone;
      repeat (40) @(posedge clk);
      #1;
      check("no_done_after_rst", 64'(ndone), 64'(nd));
      run(32'd1000, 16'd7);
      check("q_after_rst", {32'd0, quotient}, 64'd142);

      // Random sweep including divisor 1, 0xFFFF and 0
      for (int i = 0; i < 200; i++) begin
         case (i % 10)
            0:       rb = 16'd1;
            1:       rb = 16'hFFFF;
            2:       rb = (i % 40 == 2) ? 16'd0 : 16'd2;
            default: rb = W'($urandom);
         endcase
         run($urandom, rb);
      end

      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
